// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_INHIBIT,
    TX_START,
    TX_BITS,
    TX_ACK,
    TX_WAIT
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;

  // Bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Microseconds to clock cycles; 64-bit product avoids overflow at high clock rates.
  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned freq);
    logic [63:0] prod;
    prod = 64'(us) * 64'(freq);
    return 32'(prod / 64'd1000000);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, stable-count glitch filter and falling-edge pulse for one PS/2 line.
module ps2_line_filter #(
  parameter int unsigned filter_len = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CntW = $clog2(filter_len + 1);

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_fall;
  logic            w_sync;

  assign w_sync  = r_sync[1];
  assign o_level = r_level;
  assign o_fall  = r_fall;

  // Two-flop synchronizer for the asynchronous line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[0], i_line};
  end

  // Level follows the synchronized line only after filter_len stable cycles; the fall
  // pulse is registered together with the level so it coincides with the new low level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntW'(filter_len - 1)) begin
        r_cnt   <= '0;
        r_level <= w_sync;
        r_fall  <= ~w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host bus sequencer: receives device frames and transmits host commands.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned clk_freq         = 50000000,
  parameter int unsigned filter_len       = 8,
  parameter int unsigned inhibit_us       = 100,
  parameter int unsigned bit_timeout_us   = 2000,
  parameter int unsigned start_timeout_us = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_err,
  output logic       busy
);

  localparam int unsigned InhCycles   = us_to_cycles(inhibit_us, clk_freq);
  localparam int unsigned BitCycles   = us_to_cycles(bit_timeout_us, clk_freq);
  localparam int unsigned StartCycles = us_to_cycles(start_timeout_us, clk_freq);
  localparam int unsigned MaxA        = (InhCycles > BitCycles) ? InhCycles : BitCycles;
  localparam int unsigned TimerMax    = (MaxA > StartCycles) ? MaxA : StartCycles;
  localparam int unsigned TimerW      = $clog2(TimerMax + 1);

  logic w_clk_f, w_fall, w_data_f, w_data_fall_unused;

  ps2_line_filter #(.filter_len(filter_len)) u_clk_filt (
    .clk    (clk),
    .rst    (rst),
    .i_line (ps2_clk_i),
    .o_level(w_clk_f),
    .o_fall (w_fall)
  );

  ps2_line_filter #(.filter_len(filter_len)) u_data_filt (
    .clk    (clk),
    .rst    (rst),
    .i_line (ps2_data_i),
    .o_level(w_data_f),
    .o_fall (w_data_fall_unused)
  );

  ps2_state_e        r_state, w_state_d;
  logic [3:0]        r_bitcnt, w_bitcnt_d;
  logic [9:0]        r_shift, w_shift_d;
  logic [7:0]        r_tx_byte, w_tx_byte_d;
  logic [TimerW-1:0] r_timer, w_timer_d;
  logic [7:0]        r_rx_data, w_rx_data_d;
  logic              r_rx_valid, w_rx_valid_d;
  logic              r_rx_err, w_rx_err_d;
  logic              r_tx_err, w_tx_err_d;
  logic              r_data_drv, w_data_drv_d;
  logic              w_tx_ready, w_timed, w_timeout, w_tx_bit, w_frame_ok;
  logic [10:0]       w_frame;
  int unsigned       w_limit;

  // Previous ten bits plus the bit sampled now; bit 0 is the start bit on the last fall.
  assign w_frame    = {w_data_f, r_shift};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

  assign w_timed   = (r_state == RX) || (r_state == TX_START) ||
                     (r_state == TX_BITS) || (r_state == TX_ACK);
  assign w_limit   = (r_state == TX_START) ? StartCycles : BitCycles;
  assign w_timeout = w_timed && (r_timer == TimerW'(w_limit - 1));

  // Lines are decoded from state so an asynchronous reset releases them at once.
  assign ps2_clk_oe  = (r_state == TX_INHIBIT);
  assign ps2_data_oe = (r_state == TX_START) || ((r_state == TX_BITS) && r_data_drv);
  assign busy        = (r_state != IDLE);
  assign tx_ready    = w_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_err      = r_rx_err;
  assign tx_err      = r_tx_err;

  // Value of the transmit bit selected by the bit counter.
  always_comb begin
    if (r_bitcnt < 4'd8)       w_tx_bit = r_tx_byte[r_bitcnt[2:0]];
    else if (r_bitcnt == 4'd8) w_tx_bit = odd_parity(r_tx_byte);
    else                       w_tx_bit = 1'b1;
  end

  // Next-state, datapath and handshake decode.
  always_comb begin
    w_state_d    = r_state;
    w_bitcnt_d   = r_bitcnt;
    w_shift_d    = r_shift;
    w_tx_byte_d  = r_tx_byte;
    w_rx_data_d  = r_rx_data;
    w_rx_valid_d = r_rx_valid & ~rx_ready;
    w_rx_err_d   = 1'b0;
    w_tx_err_d   = 1'b0;
    w_data_drv_d = r_data_drv;
    w_tx_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_ready = w_clk_f & ~w_fall;
        if (w_fall) begin
          // Receive has priority over a command offered in the same cycle.
          w_state_d  = RX;
          w_bitcnt_d = 4'd0;
          w_shift_d  = w_frame[10:1];
        end else if (tx_valid && w_tx_ready) begin
          w_tx_byte_d = tx_data;
          w_bitcnt_d  = 4'd0;
          w_state_d   = TX_INHIBIT;
        end
      end
      RX: begin
        if (w_timeout) begin
          w_rx_err_d = 1'b1;
          w_state_d  = IDLE;
        end else if (w_fall) begin
          w_shift_d  = w_frame[10:1];
          w_bitcnt_d = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'(FRAME_BITS - 2)) begin
            w_state_d = IDLE;
            if (w_frame_ok && (!r_rx_valid || rx_ready)) begin
              w_rx_data_d  = w_frame[8:1];
              w_rx_valid_d = 1'b1;
            end else begin
              w_rx_err_d = 1'b1;
            end
          end
        end
      end
      TX_INHIBIT: begin
        if (r_timer == TimerW'(InhCycles - 1)) w_state_d = TX_START;
      end
      TX_START: begin
        if (w_timeout) begin
          w_tx_err_d = 1'b1;
          w_state_d  = IDLE;
        end else if (w_fall) begin
          w_data_drv_d = ~w_tx_bit;
          w_bitcnt_d   = r_bitcnt + 4'd1;
          w_state_d    = TX_BITS;
        end
      end
      TX_BITS: begin
        if (w_timeout) begin
          w_tx_err_d = 1'b1;
          w_state_d  = IDLE;
        end else if (w_fall) begin
          w_data_drv_d = ~w_tx_bit;
          w_bitcnt_d   = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd9) w_state_d = TX_ACK;
        end
      end
      TX_ACK: begin
        if (w_timeout) begin
          w_tx_err_d = 1'b1;
          w_state_d  = IDLE;
        end else if (w_fall) begin
          w_tx_err_d = w_data_f;
          w_state_d  = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (w_clk_f && w_data_f) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Timer restarts on state entry and on device clock falls (our own inhibit fall excluded).
  always_comb begin
    w_timer_d = r_timer;
    if ((w_state_d != r_state) || (w_fall && (r_state != TX_INHIBIT))) begin
      w_timer_d = '0;
    end else if (r_timer != TimerW'(TimerMax)) begin
      w_timer_d = r_timer + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tx_byte  <= '0;
      r_timer    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_tx_err   <= 1'b0;
      r_data_drv <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_bitcnt   <= w_bitcnt_d;
      r_shift    <= w_shift_d;
      r_tx_byte  <= w_tx_byte_d;
      r_timer    <= w_timer_d;
      r_rx_data  <= w_rx_data_d;
      r_rx_valid <= w_rx_valid_d;
      r_rx_err   <= w_rx_err_d;
      r_tx_err   <= w_tx_err_d;
      r_data_drv <= w_data_drv_d;
    end
  end

endmodule
